// File: rtl/steer_en_ctrl.sv
// steer_en_ctrl: rider detect / steer enable FSM with load-cell comparators, settle timer and step-off debounce
module steer_en_ctrl #(
  parameter int LD_W = 12,
  parameter int MIN_RIDER_WT = 'h200,
  parameter int HYST = 'h040,
  parameter int SETTLE_CNT = 65000000,
  parameter int OFF_CNT = 2500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  output logic            en_steer,
  output logic            rider_off,
  output logic            tmr_full,
  output logic [1:0]      steer_state
);
  localparam int SW = LD_W + 1;
  localparam int TW = $clog2(SETTLE_CNT + 1);
  localparam logic [SW-1:0] GT_TH = SW'(MIN_RIDER_WT + HYST);
  localparam logic [SW-1:0] LT_TH = SW'(MIN_RIDER_WT - HYST);
  typedef enum logic [1:0] {IDLE, WAIT, STEER, STEER_OFF} state_t;
  state_t st, nxt;
  logic [LD_W-1:0] lft_r, rght_r, diff;
  logic [SW-1:0] sum;
  logic [TW-1:0] tmr;
  logic clr, sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;
  assign sum = {1'b0, lft_r} + {1'b0, rght_r};
  assign diff = lft_r >= rght_r ? lft_r - rght_r : rght_r - lft_r;
  assign sum_gt_min = sum > GT_TH;
  assign sum_lt_min = sum < LT_TH;
  assign diff_gt_1_4 = {1'b0, diff} > (sum >> 2);
  assign diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));
  assign tmr_full = tmr == TW'(SETTLE_CNT);
  assign en_steer = st == STEER || st == STEER_OFF;
  assign rider_off = st == IDLE;
  assign steer_state = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_r <= '0;
      rght_r <= '0;
    end else if (ld_vld) begin
      lft_r <= lft_ld;
      rght_r <= rght_ld;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else st <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) tmr <= '0;
    else if ((st == WAIT || st == STEER_OFF) && !tmr_full) tmr <= tmr + 1'b1;
  end
  always_comb begin
    nxt = st;
    clr = 1'b0;
    case (st)
      IDLE: begin
        clr = sum_gt_min;
        nxt = sum_gt_min ? WAIT : IDLE;
      end
      WAIT: begin
        clr = !sum_lt_min && diff_gt_1_4;
        nxt = sum_lt_min ? IDLE : (!diff_gt_1_4 && tmr_full) ? STEER : WAIT;
      end
      STEER: begin
        clr = sum_lt_min || diff_gt_15_16;
        nxt = sum_lt_min ? STEER_OFF : diff_gt_15_16 ? WAIT : STEER;
      end
      STEER_OFF: begin
        clr = !sum_lt_min && diff_gt_15_16;
        nxt = sum_lt_min ? (tmr == TW'(OFF_CNT - 1) ? IDLE : STEER_OFF) : diff_gt_15_16 ? WAIT : STEER;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_steer_en_ctrl.sv
// tb_steer_en_ctrl: scoreboard bench with directed load-cell vectors
module tb_steer_en_ctrl;
  logic clk = 0, rst = 1, ld_vld = 0;
  logic [11:0] lft_ld = '0, rght_ld = '0;
  logic en_steer, rider_off, tmr_full;
  logic [1:0] steer_state;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int c; logic [1:0] st; logic en; logic off; logic tf;} exp_t;
  exp_t q[$];
  exp_t e;
  steer_en_ctrl #(.SETTLE_CNT(16), .OFF_CNT(4)) dut (
    .clk(clk), .rst(rst), .lft_ld(lft_ld), .rght_ld(rght_ld), .ld_vld(ld_vld),
    .en_steer(en_steer), .rider_off(rider_off), .tmr_full(tmr_full), .steer_state(steer_state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      tests++;
      if (e.c != cyc || {steer_state, en_steer, rider_off, tmr_full} !== {e.st, e.en, e.off, e.tf}) begin
        fails++;
        $display("FAIL outputs cyc %0d: state/en/off/full got %0d/%b/%b/%b exp %0d/%b/%b/%b (due cyc %0d)",
                 cyc, steer_state, en_steer, rider_off, tmr_full, e.st, e.en, e.off, e.tf, e.c);
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic load(input logic [11:0] l, input logic [11:0] r);
    lft_ld = l;
    rght_ld = r;
    ld_vld = 1;
    tick();
    ld_vld = 0;
  endtask
  task automatic ex(input logic [1:0] st, input logic en, input logic off, input logic tf);
    q.push_back('{cyc, st, en, off, tf});
  endtask
  task automatic mount_balanced();
    load(12'h150, 12'h150); ex(1, 0, 0, 0);
    tick(15); ex(1, 0, 0, 0);
    tick(); ex(1, 0, 0, 1);
    tick(); ex(2, 1, 0, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tick(2); ex(0, 0, 1, 0);
    rst = 0;
    tick(); ex(0, 0, 1, 0);
    load(12'h150, 12'h150); ex(0, 0, 1, 0);
    tick(); ex(1, 0, 0, 0);
    tick(15); ex(1, 0, 0, 0);
    tick(); ex(1, 0, 0, 1);
    tick(); ex(2, 1, 0, 1);
    load(12'h100, 12'h100); ex(2, 1, 0, 1);
    tick(); ex(2, 1, 0, 1);
    load(12'h0E0, 12'h0E0); ex(2, 1, 0, 1);
    tick(); ex(2, 1, 0, 1);
    load(12'h0E0, 12'h0DF); ex(2, 1, 0, 1);
    tick(); ex(3, 1, 0, 0);
    load(12'h150, 12'h150); ex(3, 1, 0, 0);
    tick(); ex(2, 1, 0, 0);
    load(12'h0E0, 12'h0DF); ex(2, 1, 0, 0);
    tick(); ex(3, 1, 0, 0);
    tick(); ex(3, 1, 0, 0);
    tick(); ex(3, 1, 0, 0);
    tick(); ex(3, 1, 0, 0);
    tick(); ex(0, 0, 1, 0);
    load(12'h120, 12'h120); ex(0, 0, 1, 0);
    tick(); ex(0, 0, 1, 0);
    tick(); ex(0, 0, 1, 0);
    load(12'h200, 12'h0A0); ex(0, 0, 1, 0);
    tick(); ex(1, 0, 0, 0);
    tick(20); ex(1, 0, 0, 0);
    mount_balanced();
    load(12'h290, 12'h010); ex(2, 1, 0, 1);
    tick(); ex(1, 0, 0, 0);
    tick(3); ex(1, 0, 0, 0);
    mount_balanced();
    rst = 1;
    lft_ld = 12'h150;
    rght_ld = 12'h150;
    ld_vld = 1;
    tick(); ex(0, 0, 1, 0);
    tick(); ex(0, 0, 1, 0);
    rst = 0;
    ld_vld = 0;
    tick(3); ex(0, 0, 1, 0);
    tick(2);
    if (q.size() > 0) begin
      $display("FAIL scoreboard: %0d expectations never checked, required 0", q.size());
      tests += q.size();
      fails += q.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
